// File: rtl/tile_row_buffer.sv
// tile_row_buffer: falling-tile row buffer with spawn LFSR, hit judging,
// IDLE/RUN/OVER game FSM and a saturating score.
module tile_row_buffer #(
  parameter int LANES = 4,
  parameter int DEPTH = 7,
  parameter int LANE_W = 3,
  parameter int LFSR_W = 8,
  parameter logic [LFSR_W-1:0] TAPS = 8'hB8,
  parameter logic [LFSR_W-1:0] SEED = 8'hA5,
  parameter int SCORE_W = 10
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     shift,
  input  logic                     spawn_en,
  input  logic                     hit_valid,
  input  logic [LANE_W-1:0]        hit_lane,
  output logic [DEPTH*LANE_W-1:0]  rows,
  output logic                     hit_ok,
  output logic                     hit_bad,
  output logic                     miss,
  output logic                     game_over,
  output logic                     running,
  output logic [SCORE_W-1:0]       score
);
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  state_t state, state_n;
  logic [LFSR_W-1:0] lfsr;
  logic [DEPTH*LANE_W-1:0] rows_n, rows_hit;
  logic [SCORE_W-1:0] score_n;
  logic [LANE_W-1:0] bottom, code;
  logic good, bad, ok_n, bad_n, miss_n;
  assign bottom = rows[(DEPTH-1)*LANE_W +: LANE_W];
  assign code = (lfsr[LANE_W-1:0] % LANE_W'(LANES)) + LANE_W'(1);
  assign good = hit_valid && hit_lane != '0 && hit_lane <= LANE_W'(LANES) && bottom == hit_lane;
  assign bad = hit_valid && !good;
  // a correct hit empties the bottom row before any same-cycle shift is judged
  assign rows_hit = good ? {LANE_W'(0), rows[(DEPTH-1)*LANE_W-1:0]} : rows;
  always_comb begin
    state_n = state;
    rows_n = rows;
    score_n = score;
    ok_n = 1'b0;
    bad_n = 1'b0;
    miss_n = 1'b0;
    if (clear) begin
      state_n = IDLE;
      rows_n = '0;
      score_n = '0;
    end else if (state == IDLE) begin
      state_n = start ? RUN : IDLE;
    end else if (state == RUN) begin
      ok_n = good;
      bad_n = bad;
      miss_n = shift && !bad && rows_hit[(DEPTH-1)*LANE_W +: LANE_W] != '0;
      state_n = (bad || miss_n) ? OVER : RUN;
      rows_n = bad ? rows
             : (shift && !miss_n) ? {rows_hit[(DEPTH-1)*LANE_W-1:0], spawn_en ? code : LANE_W'(0)}
             : rows_hit;
      score_n = (good && score != '1) ? score + 1'b1 : score;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      rows <= '0;
      score <= '0;
      hit_ok <= 1'b0;
      hit_bad <= 1'b0;
      miss <= 1'b0;
      lfsr <= SEED;
    end else begin
      state <= state_n;
      rows <= rows_n;
      score <= score_n;
      hit_ok <= ok_n;
      hit_bad <= bad_n;
      miss <= miss_n;
      lfsr <= (lfsr == '0) ? LFSR_W'(1) : {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    end
  end
  assign game_over = state == OVER;
  assign running = state == RUN;
endmodule

// File: tb/tb_tile_row_buffer.sv
// tb_tile_row_buffer: directed and randomized steps checked against a row-array game model.
module tb_tile_row_buffer;
  localparam int DEPTH = 7, LW = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;
  logic clk = 0, resetn = 0, clear = 0, start = 0, shift = 0, spawn_en = 0, hit_valid = 0;
  logic [LW-1:0] hit_lane = '0;
  logic [DEPTH*LW-1:0] rows, rows2;
  logic hit_ok, hit_bad, miss, game_over, running, ok2, bad2, miss2, go2, run2;
  logic [9:0] score;
  logic [1:0] score2;
  int n_vec = 0, n_err = 0;
  int m_rows[DEPTH];
  int m_score, m_score2, m_st;
  logic [7:0] m_lfsr;
  bit e_ok, e_bad, e_miss;

  always #5 clk = ~clk;

  tile_row_buffer u_dut (.clk(clk), .resetn(resetn), .clear(clear), .start(start), .shift(shift),
    .spawn_en(spawn_en), .hit_valid(hit_valid), .hit_lane(hit_lane), .rows(rows), .hit_ok(hit_ok),
    .hit_bad(hit_bad), .miss(miss), .game_over(game_over), .running(running), .score(score));
  tile_row_buffer #(.SCORE_W(2)) u_sat (.clk(clk), .resetn(resetn), .clear(clear), .start(start),
    .shift(shift), .spawn_en(spawn_en), .hit_valid(hit_valid), .hit_lane(hit_lane), .rows(rows2),
    .hit_ok(ok2), .hit_bad(bad2), .miss(miss2), .game_over(go2), .running(run2), .score(score2));

  function automatic logic [31:0] packed_rows();
    logic [31:0] p = '0;
    for (int r = 0; r < DEPTH; r++) p[r*LW +: LW] = LW'(m_rows[r]);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rows"}, 32'(rows), packed_rows());
    chk({tag, ".hit_ok"}, 32'(hit_ok), 32'(e_ok));
    chk({tag, ".hit_bad"}, 32'(hit_bad), 32'(e_bad));
    chk({tag, ".miss"}, 32'(miss), 32'(e_miss));
    chk({tag, ".game_over"}, 32'(game_over), 32'(m_st == M_OVER));
    chk({tag, ".running"}, 32'(running), 32'(m_st == M_RUN));
    chk({tag, ".score"}, 32'(score), 32'(m_score));
    chk({tag, ".score_sat"}, 32'(score2), 32'(m_score2));
  endtask

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) m_rows[r] = 0;
    m_score = 0;
    m_score2 = 0;
    m_st = M_IDLE;
    m_lfsr = 8'hA5;
    e_ok = 0;
    e_bad = 0;
    e_miss = 0;
  endtask

  task automatic step(input string tag, input bit c, input bit s, input bit sh, input bit sp,
                      input bit hv, input int hl);
    int code;
    clear = c; start = s; shift = sh; spawn_en = sp; hit_valid = hv; hit_lane = LW'(hl);
    e_ok = 0; e_bad = 0; e_miss = 0;
    code = (m_lfsr % 4) + 1;
    if (c) begin
      for (int r = 0; r < DEPTH; r++) m_rows[r] = 0;
      m_score = 0; m_score2 = 0; m_st = M_IDLE;
    end else if (m_st == M_RUN) begin
      if (hv) begin
        if (hl >= 1 && hl <= 4 && m_rows[DEPTH-1] == hl) begin
          e_ok = 1;
          m_rows[DEPTH-1] = 0;
          m_score = (m_score < 1023) ? m_score + 1 : 1023;
          m_score2 = (m_score2 < 3) ? m_score2 + 1 : 3;
        end else begin
          e_bad = 1;
          m_st = M_OVER;
        end
      end
      if (sh && !e_bad) begin
        if (m_rows[DEPTH-1] != 0) begin
          e_miss = 1;
          m_st = M_OVER;
        end else begin
          for (int r = DEPTH-1; r > 0; r--) m_rows[r] = m_rows[r-1];
          m_rows[0] = sp ? code : 0;
        end
      end
    end else if (m_st == M_IDLE && s) m_st = M_RUN;
    m_lfsr = (m_lfsr == 0) ? 8'h01 : {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic int wrong_lane();
    return (m_rows[DEPTH-1] % 4) + 1;
  endfunction

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    resetn = 1;
    step("start", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("fill", 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("hit", 0, 0, 0, 0, 1, m_rows[DEPTH-1]);
      step("empty_shift", 0, 0, 1, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) step("hit_shift", 0, 0, 1, 0, m_rows[DEPTH-1] != 0, m_rows[DEPTH-1]);
    for (int i = 0; i < 7; i++) step("refill", 0, 0, 1, 1, 0, 0);
    step("bad_hit", 0, 0, 0, 0, 1, wrong_lane());
    step("over_shift", 0, 0, 1, 1, 0, 0);
    step("over_hit", 0, 1, 0, 0, 1, m_rows[DEPTH-1]);
    step("clear", 1, 0, 0, 0, 0, 0);
    step("start2", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("fill2", 0, 0, 1, 1, 0, 0);
    step("miss", 0, 0, 1, 1, 0, 0);
    step("over_ign", 0, 0, 1, 1, 1, m_rows[DEPTH-1]);
    step("clear2", 1, 1, 0, 0, 0, 0);
    step("start3", 0, 1, 0, 0, 0, 0);
    step("hit_empty", 0, 0, 0, 0, 1, 1);
    step("clear3", 1, 0, 0, 0, 0, 0);
    step("start4", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("fill4", 0, 0, 1, 1, 0, 0);
    step("bad_and_shift", 0, 0, 1, 1, 1, wrong_lane());
    step("clear4", 1, 0, 0, 0, 0, 0);
    step("start5", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("fill5", 0, 0, 1, 1, 0, 0);
    step("lane_oor", 0, 0, 0, 0, 1, 5);
    for (int i = 0; i < 400; i++) begin
      bit c, hv;
      int hl;
      c = (m_st == M_OVER) ? ($urandom % 4 == 0) : ($urandom % 40 == 0);
      hv = $urandom % 3 == 0;
      hl = ($urandom % 10 < 7) ? m_rows[DEPTH-1] : int'($urandom_range(0, 7));
      step("rand", c, $urandom % 4 == 0, $urandom % 2 == 1, $urandom % 4 != 0, hv, hl);
    end
    step("pre_rst_clr", 1, 0, 0, 0, 0, 0);
    step("pre_rst_start", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("pre_rst_fill", 0, 0, 1, 1, 0, 0);
    step("pre_rst_hit", 0, 0, 0, 0, 1, m_rows[DEPTH-1]);
    #2 resetn = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    resetn = 1;
    step("post_rst_start", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("post_rst_fill", 0, 0, 1, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
